// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at accept time and committed after a fixed busy latency.
module md_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned W2      = 2 * WIDTH;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [W2-1:0]    r_pend, w_pend_nxt;
    logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic             w_signed;
    logic [W2-1:0]    w_hilo, w_a_ext, w_b_ext, w_prod, w_pend_calc;
    logic             w_a_neg, w_b_neg, w_div_zero;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;
    logic             w_accept, w_launch, w_is_div;

    // Even op codes in 0..7 are the signed variants.
    assign w_signed = ~op[0];
    assign w_hilo   = {r_hi, r_lo};

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign w_a_ext = {{WIDTH{w_signed & d1[WIDTH-1]}}, d1};
    assign w_b_ext = {{WIDTH{w_signed & d2[WIDTH-1]}}, d2};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_div_zero = (d2 == '0);
    assign w_a_neg    = w_signed & d1[WIDTH-1];
    assign w_b_neg    = w_signed & d2[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -d1 : d1;
    assign w_b_mag    = w_b_neg ? -d2 : d2;
    assign w_q_mag    = w_div_zero ? '0 : (w_a_mag / w_b_mag);
    assign w_r_mag    = w_div_zero ? '0 : (w_a_mag % w_b_mag);
    // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1) negates back to MIN.
    assign w_quo      = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem      = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_pend_calc = w_prod;
        case (op)
            4'd0, 4'd1: w_pend_calc = w_prod;
            4'd2, 4'd3: w_pend_calc = w_div_zero ? w_hilo : {w_rem, w_quo};
            4'd4, 4'd5: w_pend_calc = w_hilo + w_prod;
            4'd6, 4'd7: w_pend_calc = w_hilo - w_prod;
            default:    w_pend_calc = w_prod;
        endcase
    end

    assign w_accept = start & ~cancel & (r_state == StIdle);
    assign w_launch = w_accept & ~op[3];
    assign w_is_div = (op[3:1] == 3'b001);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_launch) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    w_pend_nxt  = w_pend_calc;
                    w_busy_nxt  = 1'b1;
                end else if (w_accept && op == 4'd8) begin
                    w_hi_nxt = d1;
                end else if (w_accept && op == 4'd9) begin
                    w_lo_nxt = d1;
                end
            end
            StRun: begin
                if (cancel) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_hi_nxt    = r_pend[W2-1:WIDTH];
                    w_lo_nxt    = r_pend[WIDTH-1:0];
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = start | r_busy;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan cases plus randomized ops
// checked against a plain-arithmetic model of HI/LO.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        cancel;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_unit #(.WIDTH(32), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .cancel(cancel), .busy(busy), .stall_req(stall_req), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [3:0] opc, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sp;
        logic [63:0] up;
        int          q, r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        case (opc)
            4'd0: return sp;
            4'd1: return up;
            4'd2: begin
                if (b == 0) return hl;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd3: return (b == 0) ? hl : {a % b, a / b};
            4'd4: return hl + sp;
            4'd5: return hl + up;
            4'd6: return hl - sp;
            4'd7: return hl - up;
            default: return hl;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present one start cycle (caller sits at a negedge); returns at the following negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        start = 1'b1; op = o; d1 = a; d2 = b; cancel = c;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0; op = 4'hF; d1 = $urandom; d2 = $urandom;
    endtask

    // Count remaining busy cycles; flags a done pulse seen while still busy.
    task automatic wait_idle(output int cyc, output bit early);
        cyc = 0; early = 1'b0;
        while (busy === 1'b1 && cyc < 200) begin
            if (done !== 1'b0) early = 1'b1;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    endtask

    task automatic test_plan;
        logic [3:0]  t_op [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd4, 4'd7};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                                  32'h10, 32'h20, 32'd3, 32'd1};
        logic [31:0] t_b  [8] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd4, 32'h2D};
        logic [31:0] t_hi [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h10, 32'h10, 32'h10, 32'h0F};
        logic [31:0] t_lo [8] = '{32'hFFFF_FFFA, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFD, 32'h20, 32'h2C, 32'hFFFF_FFFF};
        int cyc, want;
        bit early;
        // stall_req is combinational with start
        start = 1'b1; op = t_op[0]; d1 = t_a[0]; d2 = t_b[0];
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL plan_stall_start: got %b want 1", stall_req); end
        for (int i = 0; i < 8; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 1'b0);
            if (t_op[i] <= 4'd7) begin
                want = (t_op[i] == 4'd2 || t_op[i] == 4'd3) ? DIV_N : MUL_N;
                wait_idle(cyc, early);
                checks++; if (cyc != want) begin errors++; $display("FAIL plan_busy_len[%0d]: got %0d want %0d", i, cyc, want); end
                checks++; if (early) begin errors++; $display("FAIL plan_early_done[%0d]: got 1 want 0", i); end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL plan_done[%0d]: got %b want 1", i, done); end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL plan_mt_flags[%0d]: got busy=%b done=%b want 0 0", i, busy, done); end
            end
            checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL plan_hi[%0d]: got %h want %h", i, hi, t_hi[i]); end
            checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL plan_lo[%0d]: got %h want %h", i, lo, t_lo[i]); end
            m_hi = t_hi[i]; m_lo = t_lo[i];
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL plan_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_cancel;
        bit saw;
        issue(4'd2, $urandom, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel_mid_flags: got busy=%b done=%b want 0 0", busy, done); end
        saw = 1'b0;
        for (int i = 0; i < DIV_N; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw) begin errors++; $display("FAIL cancel_mid_late: got late busy/done want none"); end
        checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL cancel_mid_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); end
        // cancel coinciding with the commit edge
        issue(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (MUL_N - 1) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel_commit_flags: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL cancel_commit_hilo: got %h want %h", {hi, lo}, {m_hi, m_lo}); end
        // cancel suppresses a same-cycle start
        issue(4'd8, 32'hDEAD_BEEF, 32'h0, 1'b1);
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL cancel_mthi: got %h want %h", hi, m_hi); end
        issue(4'd0, 32'd5, 32'd7, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [63:0] e;
        int cyc;
        bit early;
        e = model(4'd1, 32'hCAFE_F00D, 32'h0000_1234, {m_hi, m_lo});
        issue(4'd1, 32'hCAFE_F00D, 32'h0000_1234, 1'b0);
        @(negedge clk);
        issue(4'd8, 32'h1111_2222, 32'h0, 1'b0);
        issue(4'd0, 32'h7, 32'h9, 1'b0);
        wait_idle(cyc, early);
        checks++; if (cyc != MUL_N - 3) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", cyc, MUL_N - 3); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_hilo: got %h want %h", {hi, lo}, e); end
        m_hi = e[63:32]; m_lo = e[31:0];
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_relaunch: got %b want 0", busy); end
    endtask

    task automatic test_undefined;
        for (int i = 10; i < 16; i++) begin
            issue(4'(i), $urandom, $urandom, 1'b0);
            checks++; if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
                errors++; $display("FAIL undef_op%0d: got busy=%b done=%b hilo=%h want 0 0 %h", i, busy, done, {hi, lo}, {m_hi, m_lo});
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic [63:0] e;
        int cyc, want;
        bit early;
        for (int n = 0; n < 60; n++) begin
            o = 4'($urandom_range(0, 11));
            a = pick();
            b = pick();
            if (o == 4'd8) e = {a, m_lo};
            else if (o == 4'd9) e = {m_hi, a};
            else e = model(o, a, b, {m_hi, m_lo});
            issue(o, a, b, 1'b0);
            if (o <= 4'd7) begin
                want = (o == 4'd2 || o == 4'd3) ? DIV_N : MUL_N;
                wait_idle(cyc, early);
                checks++; if (cyc != want || early || done !== 1'b1) begin
                    errors++; $display("FAIL rand_timing[%0d] op%0d: got cyc=%0d early=%b done=%b want %0d 0 1", n, o, cyc, early, done, want);
                end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rand_flags[%0d] op%0d: got busy=%b done=%b want 0 0", n, o, busy, done); end
            end
            checks++; if ({hi, lo} !== e) begin
                errors++; $display("FAIL rand_hilo[%0d] op%0d a=%h b=%h: got %h want %h", n, o, a, b, {hi, lo}, e);
            end
            m_hi = e[63:32]; m_lo = e[31:0];
        end
    endtask

    task automatic test_reset_mid;
        issue(4'd3, $urandom, 32'd3, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy=%b done=%b want 0 0", busy, done); end
        checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h want 0", {hi, lo}); end
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (DIV_N + 2) @(negedge clk);
        checks++; if ({busy, done, hi, lo} !== 66'h0) begin errors++; $display("FAIL rstmid_after: got busy=%b done=%b hilo=%h want all 0", busy, done, {hi, lo}); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 4'h0; d1 = '0; d2 = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_plan();
        test_cancel();
        test_back_to_back();
        test_undefined();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
